led_matrix_scan: RTL and testbench

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

---
 rtl/led_matrix_scan.sv | 119 +++++++++++
 tb/tb_led_matrix_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 4x4 LED matrix row scanner with 16-slot PWM and tear-free double buffering
module led_matrix_scan #(
  parameter int SLOT_CYCLES  = 750,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [3:0]  aled,
  output logic [3:0]  kled_tri,
  output logic        frame_start
);
  localparam int MAXC = SLOT_CYCLES > BLANK_CYCLES ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t          r_state;
  logic [1:0]      r_row;
  logic [3:0]      r_slot;
  logic [CW-1:0]   r_cnt;
  logic [63:0]     r_active;
  logic [63:0]     r_pending;
  logic            r_full;
  logic            w_blank_end;
  logic            w_slot_end;
  logic            w_row_end;
  logic            w_boundary;
  logic [15:0]     w_row_lv;
  logic [3:0]      w_next_slot;
  logic [3:0]      w_kled_nx;
  assign w_blank_end = r_cnt == CW'(BLANK_CYCLES - 1);
  assign w_slot_end  = r_cnt == CW'(SLOT_CYCLES - 1);
  assign w_row_end   = r_state == SHOW && w_slot_end && &r_slot;
  // A frame boundary is any entry into row-0 blanking, from idle or after row 3.
  assign w_boundary  = enable && (r_state == IDLE || (w_row_end && &r_row));
  assign frame_ready = !r_full;
  // Column enables for the slot about to be shown in the current row.
  always_comb begin
    w_row_lv    = r_active[{r_row, 4'b0000} +: 16];
    w_next_slot = r_state == SHOW ? r_slot + 4'd1 : 4'd0;
    for (int c = 0; c < 4; c++) w_kled_nx[c] = w_next_slot < w_row_lv[4*c +: 4];
  end
  // Pending/active buffers: swap only on a boundary, otherwise accept into pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_pending <= '0;
      r_full    <= 1'b0;
    end else if (w_boundary && r_full) begin
      r_active <= r_pending;
      r_full   <= 1'b0;
    end else if (frame_valid && !r_full) begin
      r_pending <= frame_data;
      r_full    <= 1'b1;
    end
  end
  // Scan FSM with outputs registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_slot      <= '0;
      r_cnt       <= '0;
      aled        <= '0;
      kled_tri    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        r_state  <= IDLE;
        r_row    <= '0;
        r_slot   <= '0;
        r_cnt    <= '0;
        aled     <= '0;
        kled_tri <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state     <= BLANK;
            r_row       <= '0;
            r_cnt       <= '0;
            frame_start <= 1'b1;
          end
          BLANK: begin
            if (w_blank_end) begin
              r_state  <= SHOW;
              r_slot   <= '0;
              r_cnt    <= '0;
              aled     <= 4'b0001 << r_row;
              kled_tri <= w_kled_nx;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          SHOW: begin
            if (!w_slot_end) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt <= '0;
              if (&r_slot) begin
                r_state     <= BLANK;
                r_row       <= r_row + 2'd1;
                aled        <= '0;
                kled_tri    <= '0;
                frame_start <= &r_row;
              end else begin
                r_slot   <= r_slot + 4'd1;
                kled_tri <= w_kled_nx;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: directed checks of scan timing, PWM duty and buffer swapping
module tb_led_matrix_scan;
  localparam logic [63:0] F_DAT = 64'h1000_0000_0080_000F;
  localparam logic [63:0] A_DAT = 64'h4444_4444_4444_4444;
  localparam logic [63:0] B_DAT = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] C_DAT = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D_DAT = 64'h5555_5555_5555_5555;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] frame_data = '0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [3:0]  aled;
  logic [3:0]  kled_tri;
  logic        frame_start;
  int n_cmp = 0;
  int n_bad = 0;
  int lit [4][4];
  int show_cnt [4];
  int bad_cnt, fs_cnt, wait_n;
  logic ready_pre, ready_fs;

  led_matrix_scan #(.SLOT_CYCLES(2), .BLANK_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .aled(aled),
    .kled_tri(kled_tri), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for frame_start, then tallies one 132-cycle frame.
  task automatic measure_frame(input string tag);
    wait_n = 0;
    ready_pre = 1'b1;
    bad_cnt = 0;
    fs_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      show_cnt[r] = 0;
      for (int c = 0; c < 4; c++) lit[r][c] = 0;
    end
    while (!frame_start && wait_n < 300) begin
      ready_pre = frame_ready;
      step(1);
      wait_n++;
    end
    if (!frame_start) chk({tag, "_fs_timeout"}, 0, 1);
    ready_fs = frame_ready;
    for (int i = 0; i < 132; i++) begin
      fs_cnt += int'(frame_start);
      if (!$onehot0(aled) || (aled == 4'b0 && kled_tri != 4'b0)) bad_cnt++;
      for (int r = 0; r < 4; r++) begin
        show_cnt[r] += int'(aled[r]);
        for (int c = 0; c < 4; c++) lit[r][c] += int'(aled[r] & kled_tri[c]);
      end
      step(1);
    end
  endtask

  // Each LED of brightness b is lit for b slots of 2 cycles.
  task automatic check_frame(input string tag, input logic [63:0] d);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("%s_show%0d", tag, r), show_cnt[r], 32);
      for (int c = 0; c < 4; c++)
        chk($sformatf("%s_lit%0d", tag, 4*r+c), lit[r][c], 2 * int'(d[(4*r+c)*4 +: 4]));
    end
    chk({tag, "_fs_cnt"}, fs_cnt, 1);
    chk({tag, "_onehot"}, bad_cnt, 0);
  endtask

  initial begin
    step(2);
    chk("rst_aled", int'(aled), 0);
    chk("rst_kled", int'(kled_tri), 0);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_ready", int'(frame_ready), 1);
    rst = 1'b0;
    step(1);
    chk("post_rst_aled", int'(aled), 0);
    chk("post_rst_ready", int'(frame_ready), 1);
    // Free-running scan with an all-dark buffer.
    enable = 1'b1;
    measure_frame("dark0");
    chk("first_fs_lat", wait_n, 1);
    check_frame("dark0", '0);
    measure_frame("dark1");
    chk("fs_period", wait_n, 0);
    check_frame("dark1", '0);
    // Single frame, displayed from the next boundary.
    step(10);
    chk("f_ready_pre", int'(frame_ready), 1);
    frame_data = F_DAT;
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
    chk("f_ready_acc", int'(frame_ready), 0);
    measure_frame("f");
    chk("f_ready_held", int'(ready_pre), 0);
    chk("f_ready_back", int'(ready_fs), 1);
    check_frame("f", F_DAT);
    // Back-to-back A then B; B waits for the swap.
    frame_data = A_DAT;
    frame_valid = 1'b1;
    step(1);
    chk("a_acc", int'(frame_ready), 0);
    frame_data = B_DAT;
    fork
      measure_frame("a");
      begin
        for (int n = 0; n < 300 && !frame_ready; n++) step(1);
        step(1);
        chk("b_acc", int'(frame_ready), 0);
        frame_valid = 1'b0;
      end
    join
    chk("b_held_ready", int'(ready_pre), 0);
    chk("a_swap_ready", int'(ready_fs), 1);
    check_frame("a", A_DAT);
    measure_frame("b");
    chk("b_period", wait_n, 0);
    check_frame("b", B_DAT);
    // Offer C exactly on the boundary edge with full=0.
    step(131);
    frame_data = C_DAT;
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
    chk("c_fs", int'(frame_start), 1);
    chk("c_acc", int'(frame_ready), 0);
    measure_frame("not_c");
    chk("not_c_wait", wait_n, 0);
    check_frame("not_c", B_DAT);
    measure_frame("c");
    check_frame("c", C_DAT);
    // Drop enable in the middle of row 2 SHOW.
    step(80);
    chk("en_row2", int'(aled), 4);
    enable = 1'b0;
    step(1);
    chk("en_off_aled", int'(aled), 0);
    chk("en_off_kled", int'(kled_tri), 0);
    step(5);
    chk("en_off_idle", int'(aled), 0);
    enable = 1'b1;
    step(1);
    chk("en_on_fs", int'(frame_start), 1);
    chk("en_on_blank", int'(aled), 0);
    step(1);
    chk("en_on_fs_end", int'(frame_start), 0);
    chk("en_on_row0", int'(aled), 1);
    chk("en_on_kled", int'(kled_tri), 15);
    // Asynchronous reset mid-SHOW with a pending frame.
    frame_data = D_DAT;
    frame_valid = 1'b1;
    step(1);
    frame_valid = 1'b0;
    chk("d_acc", int'(frame_ready), 0);
    step(3);
    chk("d_show", int'(aled), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_aled", int'(aled), 0);
    chk("arst_kled", int'(kled_tri), 0);
    chk("arst_fs", int'(frame_start), 0);
    chk("arst_ready", int'(frame_ready), 1);
    step(3);
    rst = 1'b0;
    measure_frame("post_arst");
    chk("post_arst_lat", wait_n, 1);
    check_frame("post_arst", '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
